// File: rtl/xm23_mem_responder.sv
// XM23 memory-port target: byte-addressed RAM with programmable wait states and a one-cycle ack.
// Optional breakpoint compare on read addresses is enabled by defining XM23_RESP_BKPT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a request with a read or write bit set
// ST_WAIT   | request latched, down-counting programmed wait states
// ST_ACCESS | RAM access performed, ack/err registered on exit
module xm23_mem_responder #(
   parameter int DEPTH_LOG2  = 16,
   parameter int WAIT_STATES = 1
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic        req,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   input  logic [2:0]  ctrl,
`ifdef XM23_RESP_BKPT_EN
   input  logic [15:0] bkpnt,
   output logic        bkpt_hit,
`endif
   output logic [15:0] rdata,
   output logic        ack,
   output logic        busy,
   output logic        err
);

   localparam int         DEPTH   = 2 ** DEPTH_LOG2;
   localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS
   } state_t;

   state_t                state, state_nxt;
   logic [3:0]            cnt, cnt_nxt;
   logic [15:0]           lat_addr, lat_wdata;
   logic [2:0]            lat_ctrl;
   logic                  accept;
   logic                  ack_nxt, busy_nxt, err_nxt;
   logic [15:0]           rdata_nxt;
   logic [DEPTH_LOG2-1:0] a0, a1;
   logic                  bad, do_rd, do_wr;
   logic [7:0]            mem [DEPTH];

   // Upper byte address wraps naturally at the RAM size.
   assign a0    = lat_addr[DEPTH_LOG2-1:0];
   assign a1    = a0 + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   assign bad   = (lat_ctrl[1:0] == 2'b11) || (!lat_ctrl[2] && a0[0]);
   assign do_rd = (state == ST_ACCESS) && !bad && lat_ctrl[0];
   assign do_wr = (state == ST_ACCESS) && !bad && lat_ctrl[1];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      ack_nxt   = 1'b0;
      busy_nxt  = busy;
      err_nxt   = 1'b0;
      rdata_nxt = rdata;
      case (state)
         ST_IDLE: begin
            if (req && (ctrl[1:0] != 2'b00)) begin
               accept   = 1'b1;
               busy_nxt = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = WAIT_LD;
               end else begin
                  state_nxt = ST_ACCESS;
               end
            end
         end
         ST_WAIT: begin
            if (cnt <= 4'd1) begin
               state_nxt = ST_ACCESS;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         ST_ACCESS: begin
            state_nxt = ST_IDLE;
            ack_nxt   = 1'b1;
            busy_nxt  = 1'b0;
            err_nxt   = bad;
            if (do_rd)
               rdata_nxt = lat_ctrl[2] ? {8'h00, mem[a0]} : {mem[a1], mem[a0]};
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         ack       <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
         rdata     <= 16'h0000;
         lat_addr  <= 16'h0000;
         lat_wdata <= 16'h0000;
         lat_ctrl  <= 3'b000;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ack   <= ack_nxt;
         busy  <= busy_nxt;
         err   <= err_nxt;
         rdata <= rdata_nxt;
         if (accept) begin
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_ctrl  <= ctrl;
         end
      end
   end

   // RAM has no reset; a reset edge still suppresses the pending write.
   always_ff @(posedge Clock) begin
      if (Reset_n && do_wr) begin
         mem[a0] <= lat_wdata[7:0];
         if (!lat_ctrl[2])
            mem[a1] <= lat_wdata[15:8];
      end
   end

`ifdef XM23_RESP_BKPT_EN
   logic bkpt_nxt;

   // Bit 0 is masked so any byte within the breakpoint word matches.
   assign bkpt_nxt = do_rd && (((lat_addr ^ bkpnt) & 16'hFFFE) == 16'h0000);

   always_ff @(posedge Clock) begin
      if (!Reset_n)
         bkpt_hit <= 1'b0;
      else
         bkpt_hit <= bkpt_nxt;
   end
`endif

endmodule

// File: tb/tb_xm23_mem_responder.sv
// Scoreboard bench for xm23_mem_responder: one instance with one wait state, one with none.
module tb_xm23_mem_responder;

   logic Clock = 1'b0;
   always #5 Clock = ~Clock;

   logic        Reset_n;
   logic        req_a, req_b;
   logic [15:0] addr_a, wdata_a, addr_b, wdata_b;
   logic [2:0]  ctrl_a, ctrl_b;
   logic [15:0] rdata_a, rdata_b;
   logic        ack_a, busy_a, err_a, ack_b, busy_b, err_b;
   logic [15:0] bkpnt;
`ifdef XM23_RESP_BKPT_EN
   logic        bkpt_a, bkpt_b;
`endif

   xm23_mem_responder #(.DEPTH_LOG2(16), .WAIT_STATES(1)) dut_a (
      .Clock(Clock), .Reset_n(Reset_n), .req(req_a), .addr(addr_a), .wdata(wdata_a),
      .ctrl(ctrl_a),
`ifdef XM23_RESP_BKPT_EN
      .bkpnt(bkpnt), .bkpt_hit(bkpt_a),
`endif
      .rdata(rdata_a), .ack(ack_a), .busy(busy_a), .err(err_a));

   xm23_mem_responder #(.DEPTH_LOG2(16), .WAIT_STATES(0)) dut_b (
      .Clock(Clock), .Reset_n(Reset_n), .req(req_b), .addr(addr_b), .wdata(wdata_b),
      .ctrl(ctrl_b),
`ifdef XM23_RESP_BKPT_EN
      .bkpnt(bkpnt), .bkpt_hit(bkpt_b),
`endif
      .rdata(rdata_b), .ack(ack_b), .busy(busy_b), .err(err_b));

   typedef struct {
      logic [15:0] rd;
      logic        er;
      logic        bk;
      int          acc;
   } exp_t;

   exp_t        qa[$], qb[$];
   logic [7:0]  mm[int];
   logic [15:0] last_rd [2];
   int          n_chk = 0, n_err = 0;
   int          cyc = 0;
   int          nb_acks = 0, last_ack_b = 0;

   logic [15:0] b_addr [6] = '{16'h0020, 16'h0022, 16'h0024, 16'h0020, 16'h0022, 16'h0024};
   logic [15:0] b_wd   [6] = '{16'hA1A1, 16'hB2B2, 16'hC3C3, 16'h0000, 16'h0000, 16'h0000};
   logic [2:0]  b_ctrl [6] = '{3'b010, 3'b010, 3'b010, 3'b001, 3'b001, 3'b001};

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: separate byte spaces per instance (instance b offset by 64K).
   task automatic predict(input logic [15:0] a, input logic [15:0] wd, input logic [2:0] c,
                          input int inst, output exp_t e);
      int          base;
      logic [15:0] a1;
      base  = inst * 65536;
      a1    = a + 16'd1;
      e.er  = (c[1:0] == 2'b11) || (!c[2] && a[0]);
      e.rd  = last_rd[inst];
      e.bk  = 1'b0;
      e.acc = 0;
      if (!e.er) begin
         if (c[0]) begin
            e.rd = c[2] ? {8'h00, mm[base + int'(a)]} : {mm[base + int'(a1)], mm[base + int'(a)]};
            last_rd[inst] = e.rd;
            e.bk = (a[15:1] == bkpnt[15:1]);
         end else begin
            mm[base + int'(a)] = wd[7:0];
            if (!c[2]) mm[base + int'(a1)] = wd[15:8];
         end
      end
   endtask

   task automatic drive_a(input logic [15:0] a, input logic [15:0] wd, input logic [2:0] c);
      exp_t e;
      bit   got;
      predict(a, wd, c, 0, e);
      @(negedge Clock);
      req_a = 1'b1; addr_a = a; wdata_a = wd; ctrl_a = c;
      @(negedge Clock);
      chk_eq("a_busy_after_accept", busy_a, 1);
      e.acc = cyc;
      qa.push_back(e);
      addr_a = 16'($urandom); wdata_a = 16'($urandom); ctrl_a = 3'($urandom);
      @(negedge Clock);
      req_a = 1'b0; addr_a = 16'($urandom); wdata_a = 16'($urandom); ctrl_a = 3'($urandom);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge Clock);
         got = ack_a;
      end
      if (!got) chk_eq("a_ack_timeout", 0, 1);
   endtask

   always @(negedge Clock) begin : mon_a
      exp_t e;
      if (Reset_n && ack_a) begin
         if (qa.size() == 0) begin
            chk_eq("a_spurious_ack", 1, 0);
         end else begin
            e = qa.pop_front();
            chk_eq("a_rdata", rdata_a, e.rd);
            chk_eq("a_err", err_a, e.er);
            chk_eq("a_latency", cyc - e.acc, 2);
            chk_eq("a_busy_at_ack", busy_a, 0);
`ifdef XM23_RESP_BKPT_EN
            chk_eq("a_bkpt_hit", bkpt_a, e.bk);
`endif
         end
      end
   end

   always @(negedge Clock) begin : mon_b
      exp_t e;
      if (Reset_n && ack_b) begin
         if (qb.size() == 0) begin
            chk_eq("b_spurious_ack", 1, 0);
         end else begin
            e = qb.pop_front();
            chk_eq("b_rdata", rdata_b, e.rd);
            chk_eq("b_err", err_b, e.er);
            chk_eq("b_latency", cyc - e.acc, 1);
`ifdef XM23_RESP_BKPT_EN
            chk_eq("b_bkpt_hit", bkpt_b, e.bk);
`endif
         end
         if (nb_acks > 0) chk_eq("b_ack_spacing", cyc - last_ack_b, 2);
         nb_acks++;
         last_ack_b = cyc;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      bit   got;
      Reset_n = 1'b0;
      req_a = 1'b0; addr_a = '0; wdata_a = '0; ctrl_a = '0;
      req_b = 1'b0; addr_b = '0; wdata_b = '0; ctrl_b = '0;
      bkpnt = 16'h0004;
      last_rd[0] = 16'h0000;
      last_rd[1] = 16'h0000;
      repeat (3) @(negedge Clock);
      chk_eq("rst_a_outputs", {rdata_a, ack_a, busy_a, err_a}, 0);
      chk_eq("rst_b_outputs", {rdata_b, ack_b, busy_b, err_b}, 0);
      Reset_n = 1'b1;

      // request with no read/write bit is ignored
      @(negedge Clock);
      req_a = 1'b1; ctrl_a = 3'b000; addr_a = 16'h0100;
      repeat (3) begin
         @(negedge Clock);
         chk_eq("ignored_req_busy", busy_a, 0);
      end
      req_a = 1'b0;

      // word write/read, byte read of upper half, byte overwrite
      drive_a(16'h0100, 16'h1234, 3'b010);
      drive_a(16'h0100, 16'h0000, 3'b001);
      drive_a(16'h0101, 16'h0000, 3'b101);
      drive_a(16'h0101, 16'hFFAB, 3'b110);
      drive_a(16'h0100, 16'h0000, 3'b001);
      drive_a(16'h0100, 16'h0000, 3'b101);

      // error cases leave RAM and rdata untouched
      drive_a(16'h0103, 16'h0000, 3'b001);
      drive_a(16'h0100, 16'hDEAD, 3'b011);
      drive_a(16'h0101, 16'h9999, 3'b010);
      drive_a(16'h0100, 16'h0000, 3'b001);

      // top-of-memory word
      drive_a(16'hFFFE, 16'hC0DE, 3'b010);
      drive_a(16'hFFFF, 16'h0000, 3'b101);
      drive_a(16'hFFFE, 16'h0000, 3'b001);

      // breakpoint word at 0x0004
      drive_a(16'h0004, 16'h1111, 3'b010);
      drive_a(16'h0006, 16'h2222, 3'b010);
      drive_a(16'h0004, 16'h0000, 3'b001);
      drive_a(16'h0006, 16'h0000, 3'b001);
      drive_a(16'h0005, 16'h0000, 3'b101);

      // reset during the wait state of a write aborts it
      drive_a(16'h0010, 16'h5A5A, 3'b010);
      drive_a(16'h0010, 16'h0000, 3'b001);
      @(negedge Clock);
      req_a = 1'b1; addr_a = 16'h0010; wdata_a = 16'hBEEF; ctrl_a = 3'b010;
      @(negedge Clock);
      chk_eq("abort_accepted", busy_a, 1);
      req_a = 1'b0;
      Reset_n = 1'b0;
      @(negedge Clock);
      chk_eq("abort_rst_outputs", {rdata_a, ack_a, busy_a, err_a}, 0);
      Reset_n = 1'b1;
      last_rd[0] = 16'h0000;
      last_rd[1] = 16'h0000;
      repeat (4) begin
         @(negedge Clock);
         chk_eq("abort_no_ack", ack_a, 0);
      end
      drive_a(16'h0010, 16'h0000, 3'b001);

      // back-to-back on the zero-wait instance, inputs scrambled while busy
      @(negedge Clock);
      req_b = 1'b1;
      for (int i = 0; i < 6; i++) begin
         addr_b = b_addr[i]; wdata_b = b_wd[i]; ctrl_b = b_ctrl[i];
         predict(b_addr[i], b_wd[i], b_ctrl[i], 1, e);
         got = 1'b0;
         for (int k = 0; k < 10 && !got; k++) begin
            @(negedge Clock);
            got = busy_b;
         end
         if (!got) chk_eq("b_accept_timeout", 0, 1);
         e.acc = cyc;
         qb.push_back(e);
         addr_b  = 16'h0020 + 16'($urandom_range(0, 6));
         wdata_b = 16'($urandom);
         ctrl_b  = 3'b010;
         @(negedge Clock);
      end
      req_b = 1'b0;

      repeat (6) @(negedge Clock);
      chk_eq("a_queue_drained", qa.size(), 0);
      chk_eq("b_queue_drained", qb.size(), 0);
      chk_eq("b_ack_count", nb_acks, 6);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
